// File: rtl/uart_tx_device.sv
// uart_tx_device
// Memory-mapped 8N1 serial transmitter on the shared abus/dbus/we I/O bus.
// The CPU writes a byte into a one-deep holding register (TDATA). The
// transmit FSM moves it into a shifter and sends it LSB first: one start
// bit (0), eight data bits, one stop bit (1), each held for BAUD_DIV clocks.
// TCTRL reports Ready (holding empty), Busy (FSM active) and a sticky
// Overrun flag, and holds the interrupt enable IE. intr = Ready & IE.

module uart_tx_device #(
  // Clock cycles per serial bit; must be at least 2.
  parameter int unsigned BAUD_DIV   = 434,
  parameter logic [31:0] TDATA_ADDR = 32'hF000_0030,
  parameter logic [31:0] TCTRL_ADDR = 32'hF000_0130
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      abus,
  inout  wire logic [31:0] dbus,
  input  logic             we,
  output logic             intr,
  output logic             txd
);

  // Baud counter runs 0..BAUD_DIV-1 while a frame is on the line.
  localparam int unsigned    CNT_W    = $clog2(BAUD_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  // ---------------------------------------------------------------------
  // Registered state
  // ---------------------------------------------------------------------
  // Bus-visible registers.
  logic       ready;     // holding register empty
  logic       overrun;   // a TDATA write arrived while holding was full
  logic       ie;        // interrupt enable
  logic [7:0] holding;   // byte waiting to be transmitted

  // Transmitter.
  tx_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shifter;
  logic             txd_q;

  // Next-state values computed by the FSM combinational process.
  tx_state_t        state_d;
  logic [CNT_W-1:0] cnt_d;
  logic [2:0]       bit_idx_d;
  logic [7:0]       shifter_d;
  logic             txd_d;
  logic             load;      // FSM takes the holding byte on this edge

  // ---------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------
  logic        wr_data;
  logic        wr_ctrl;
  logic        rd_en;
  logic [31:0] rd_data;
  logic        busy;
  logic        baud_end;

  assign wr_data  = we && (abus == TDATA_ADDR);
  assign wr_ctrl  = we && (abus == TCTRL_ADDR);
  assign busy     = (state != IDLE);
  assign baud_end = (cnt == CNT_LAST);

  // Only dbus[8:0] carry meaning on writes; the upper bits are don't-care.
  logic unused_dbus_hi;
  assign unused_dbus_hi = ^dbus[31:9];

  // Read mux: drive the bus only for a read that hits one of our registers.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so
    // no path through the block leaves a value unassigned and infers a latch.
    rd_en   = 1'b0;
    rd_data = '0;
    if (!we) begin
      if (abus == TDATA_ADDR) begin
        rd_en   = 1'b1;
        rd_data = {24'b0, holding};
      end else if (abus == TCTRL_ADDR) begin
        rd_en   = 1'b1;
        rd_data = {23'b0, ie, 5'b0, overrun, busy, ready};
      end
    end
  end

  assign dbus = rd_en ? rd_data : 'z;

  // ---------------------------------------------------------------------
  // Bus-visible registers
  // ---------------------------------------------------------------------
  // A TDATA write is judged on the pre-edge Ready. If the FSM drains the
  // holding register on the same edge as a write that found it full, the
  // byte is still dropped and Overrun set; Ready ends up 1 from the load.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (rst) begin
      ready   <= 1'b1;
      overrun <= 1'b0;
      ie      <= 1'b0;
      holding <= 8'h00;
    end else begin
      if (wr_data && ready) begin
        holding <= dbus[7:0];
        ready   <= 1'b0;
      end else if (load) begin
        ready   <= 1'b1;
      end

      // Set has priority over clear.
      if (wr_data && !ready) begin
        overrun <= 1'b1;
      end else if (wr_ctrl && !dbus[2]) begin
        overrun <= 1'b0;
      end

      if (wr_ctrl) begin
        ie <= dbus[8];
      end
    end
  end

  // ---------------------------------------------------------------------
  // Transmit FSM
  // ---------------------------------------------------------------------
  // State register and transmit datapath; reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shifter <= 8'h00;
      txd_q   <= 1'b1;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      bit_idx <= bit_idx_d;
      shifter <= shifter_d;
      txd_q   <= txd_d;
    end
  end

  // Next-state and next-line logic; txd changes only on a counter wrap
  // (or on the load edge out of IDLE), so every bit lasts BAUD_DIV clocks.
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    bit_idx_d = bit_idx;
    shifter_d = shifter;
    txd_d     = txd_q;
    load      = 1'b0;

    case (state)
      IDLE: begin
        if (!ready) begin
          load      = 1'b1;
          shifter_d = holding;
          txd_d     = 1'b0;
          cnt_d     = '0;
          state_d   = START;
        end
      end

      START: begin
        if (baud_end) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          txd_d     = shifter[0];
          state_d   = DATA;
        end else begin
          cnt_d = cnt + CNT_ONE;
        end
      end

      DATA: begin
        if (baud_end) begin
          cnt_d = '0;
          if (bit_idx == 3'd7) begin
            txd_d   = 1'b1;
            state_d = STOP;
          end else begin
            shifter_d = {1'b0, shifter[7:1]};
            txd_d     = shifter[1];
            bit_idx_d = bit_idx + 3'd1;
          end
        end else begin
          cnt_d = cnt + CNT_ONE;
        end
      end

      STOP: begin
        if (baud_end) begin
          cnt_d = '0;
          if (!ready) begin
            // Back-to-back frame: straight into the next start bit.
            load      = 1'b1;
            shifter_d = holding;
            txd_d     = 1'b0;
            state_d   = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt + CNT_ONE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign txd  = txd_q;
  assign intr = ready & ie;

endmodule

// File: tb/tb_uart_tx_device.sv
// tb_uart_tx_device
// Self-checking bench for uart_tx_device with BAUD_DIV=4. A behavioural
// model keeps Ready/Overrun/IE/holding and a queue of future line levels
// (one entry per clock, a whole frame pushed when a byte is taken). A
// compare process checks txd, intr and any read on the bus every cycle.
// Directed scenarios pin the model with hand-computed frames and status
// words; a randomized phase follows.

module tb_uart_tx_device;

  localparam int          BD    = 4;
  localparam logic [31:0] TDATA = 32'hF000_0030;
  localparam logic [31:0] TCTRL = 32'hF000_0130;
  localparam logic [31:0] OTHER = 32'hF000_0034;
  localparam logic [31:0] FLOAT = 32'hFFFF_FFFF;  // undriven bus, pulled up
  localparam int          HN    = 8192;

  logic        clk      = 1'b0;
  logic        rst      = 1'b1;
  logic [31:0] abus     = TCTRL;
  logic        we       = 1'b0;
  logic [31:0] tb_dout  = '0;
  logic        tb_drive = 1'b0;
  wire  [31:0] dbus;
  logic        intr;
  logic        txd;

  assign dbus = tb_drive ? tb_dout : 'z;
  pullup (dbus);

  uart_tx_device #(
    .BAUD_DIV  (BD),
    .TDATA_ADDR(TDATA),
    .TCTRL_ADDR(TCTRL)
  ) dut (
    .clk (clk),
    .rst (rst),
    .abus(abus),
    .dbus(dbus),
    .we  (we),
    .intr(intr),
    .txd (txd)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------
  // Bookkeeping
  // ---------------------------------------------------------------------
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int wr_edge = 0;
  logic hist [HN];

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------
  logic       m_valid = 1'b0;
  logic       m_ready, m_busy, m_ovr, m_ie, m_txd;
  logic [7:0] m_hold;
  bit         m_line[$];

  function automatic logic [31:0] ctrl_exp();
    return {23'b0, m_ie, 5'b0, m_ovr, m_busy, m_ready};
  endfunction

  task automatic model_step();
    logic       pre_ready;
    logic [7:0] pre_hold;
    bit         v;
    pre_ready = m_ready;
    pre_hold  = m_hold;
    cyc++;
    if (rst) begin
      m_valid = 1'b1;
      m_ready = 1'b1;
      m_busy  = 1'b0;
      m_ovr   = 1'b0;
      m_ie    = 1'b0;
      m_txd   = 1'b1;
      m_hold  = 8'h00;
      m_line.delete();
      return;
    end
    // Line is free (idle, or the last stop-bit clock has just gone out):
    // take a pending byte and queue its whole 10-bit frame.
    if (m_line.size() == 0 && !pre_ready) begin
      for (int b = 0; b < 10; b++) begin
        if (b == 0)      v = 1'b0;
        else if (b == 9) v = 1'b1;
        else             v = pre_hold[b-1];
        repeat (BD) m_line.push_back(v);
      end
      m_ready = 1'b1;
    end
    if (m_line.size() > 0) begin
      m_txd  = m_line.pop_front();
      m_busy = 1'b1;
    end else begin
      m_txd  = 1'b1;
      m_busy = 1'b0;
    end
    // Bus writes, judged on pre-edge Ready.
    if (we && abus == TDATA) begin
      if (pre_ready) begin
        m_hold  = tb_dout[7:0];
        m_ready = 1'b0;
      end else begin
        m_ovr = 1'b1;
      end
    end else if (we && abus == TCTRL) begin
      m_ie = tb_dout[8];
      if (!tb_dout[2]) m_ovr = 1'b0;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Per-cycle comparison, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      hist[cyc % HN] = txd;
      check("txd", txd, m_txd);
      check("intr", intr, m_ready & m_ie);
      if (!we) begin
        if (abus == TDATA)      check("rd_tdata", dbus, {24'b0, m_hold});
        else if (abus == TCTRL) check("rd_tctrl", dbus, ctrl_exp());
        else                    check("rd_other_float", dbus, FLOAT);
      end
    end
  end

  // ---------------------------------------------------------------------
  // Bus helpers (called at posedge+1)
  // ---------------------------------------------------------------------
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    abus     = a;
    we       = 1'b1;
    tb_dout  = d;
    tb_drive = 1'b1;
    @(posedge clk); #1;
    wr_edge  = cyc;
    we       = 1'b0;
    tb_drive = 1'b0;
    abus     = TCTRL;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    abus = a;
    we   = 1'b0;
    #1;
    d = dbus;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    logic [31:0] d;
    for (int i = 0; i < 200 && !(m_ready && !m_busy); i++) begin
      @(posedge clk); #1;
    end
    rd(TCTRL, d);
    check("idle_busy", d[1], 1'b0);
  endtask

  function automatic logic [79:0] frame_bits(input int first, input int n);
    logic [79:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v = {v[78:0], hist[(first + i) % HN]};
    return v;
  endfunction

  // ---------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------
  initial begin
    logic [31:0] d;
    int          e0;
    int          sel;
    logic [31:0] a;

    // 1. Reset for two clocks.
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("s1_txd", txd, 1'b1);
    check("s1_intr", intr, 1'b0);
    rd(TCTRL, d); check("s1_tctrl", d, 32'h0000_0001);
    rd(TDATA, d); check("s1_tdata", d, 32'h0000_0000);
    rd(OTHER, d); check("s1_other_float", d, FLOAT);
    abus = TCTRL;

    // 2. Single frame of 0xA5.
    wr(TDATA, 32'h0000_01A5);
    e0 = wr_edge;
    rd(TCTRL, d); check("s2_ready_low", d, 32'h0000_0000);
    @(posedge clk); #1;
    rd(TCTRL, d); check("s2_midframe", d, 32'h0000_0003);
    wait_cyc(e0 + 41);
    rd(TCTRL, d); check("s2_after", d, 32'h0000_0001);
    check("s2_frame", frame_bits(e0 + 1, 40), 80'h0F0F00F0FF);

    // 3. Back-to-back 0x55, 0x0F; 0x77 overruns.
    wr(TDATA, 32'h55);
    e0 = wr_edge;
    wr(TDATA, 32'h0F);
    wr(TDATA, 32'h77);
    wait_cyc(e0 + 82);
    check("s3_frames", frame_bits(e0 + 1, 80), 80'h0F0F0F0F0F_0FFFF0000F);
    check("s3_line_idle", hist[(e0 + 81) % HN], 1'b1);
    rd(TCTRL, d); check("s3_status", d, 32'h0000_0005);

    // 4. Overrun clearing.
    wr(TCTRL, 32'h104);
    rd(TCTRL, d); check("s4_keep_ovr", d, 32'h0000_0105);
    wr(TCTRL, 32'h100);
    rd(TCTRL, d); check("s4_clear_ovr", d, 32'h0000_0101);

    // 5. Interrupt.
    check("s5_intr_idle", intr, 1'b1);
    wr(TDATA, 32'h3C);
    e0 = wr_edge;
    check("s5_intr_drop", intr, 1'b0);
    @(posedge clk); #1;
    check("s5_intr_back", intr, 1'b1);
    wait_cyc(e0 + 41);
    wr(TCTRL, 32'h0);
    check("s5_intr_off", intr, 1'b0);
    rd(TCTRL, d); check("s5_tctrl", d, 32'h0000_0001);

    // 6. Reset during data bit 3 of 0xC3, then a clean 0x81 frame.
    wr(TDATA, 32'hC3);
    e0 = wr_edge;
    wait_cyc(e0 + 17);
    check("s6_bit3", txd, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("s6_txd_reset", txd, 1'b1);
    rd(TCTRL, d); check("s6_tctrl_reset", d, 32'h0000_0001);
    repeat (3) @(posedge clk);
    #1;
    check("s6_still_idle", txd, 1'b1);
    wr(TDATA, 32'h81);
    e0 = wr_edge;
    wait_cyc(e0 + 42);
    check("s6_frame", frame_bits(e0 + 1, 40), 80'h0F000000FF);
    check("s6_line_idle", hist[(e0 + 41) % HN], 1'b1);
    wait_idle();

    // Randomized traffic against the model.
    for (int op = 0; op < 400; op++) begin
      sel = $urandom_range(0, 99);
      if (sel < 40) begin
        if ($urandom_range(0, 1) == 1) begin
          for (int i = 0; i < 80 && !m_ready; i++) begin
            @(posedge clk); #1;
          end
        end
        wr(TDATA, $urandom());
      end else if (sel < 55) begin
        wr(TCTRL, $urandom());
      end else if (sel < 65) begin
        a = $urandom();
        if (a == TDATA || a == TCTRL) a = OTHER;
        wr(a, $urandom());
      end else if (sel < 80) begin
        case ($urandom_range(0, 2))
          0:       abus = TDATA;
          1:       abus = TCTRL;
          default: abus = OTHER;
        endcase
        we = 1'b0;
        repeat ($urandom_range(1, 5)) @(posedge clk);
        #1;
        abus = TCTRL;
      end else if (sel < 98) begin
        repeat ($urandom_range(1, 45)) @(posedge clk);
        #1;
      end else begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
      end
    end
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time bound.
  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_tx_device.md
Name: uart_tx_device

Overview:
- Memory-mapped serial transmitter on the shared abus/dbus/we I/O bus. It is the output-direction counterpart of the KEY input device.
- The CPU writes bytes to a data register. The block buffers one byte and shifts it out on txd as 8N1 frames (LSB first, line idle high).
- It reports Ready/Busy/Overrun status in a control register and raises intr when Ready and IE are both set.

Parameters:
- BAUD_DIV, 434, clock cycles per serial bit (434 gives 115200 baud at 50 MHz); must be at least 2.
- TDATA_ADDR, 32'hF0000030, address of the data register.
- TCTRL_ADDR, 32'hF0000130, address of the control/status register.

Ports:
- clk  input  1  system clock
- rst  input  1  reset: rst, synchronous, active-high; clock clk
- abus  input  32  bus address
- dbus  inout  32  bus data; driven only on reads of this block's addresses, otherwise 32'hz
- we  input  1  bus write enable (1 = write, 0 = read)
- intr  output  1  interrupt request = TCTRL.Ready & TCTRL.IE
- txd  output  1  serial line out

Behaviour:
- TCTRL bit fields:
  - bit0 Ready: holding buffer empty.
  - bit1 Busy: transmit FSM not IDLE.
  - bit2 Overrun.
  - bit8 IE.
  - All other bits read 0.
- Reset values (at the posedge with rst=1): Ready=1, Busy=0, Overrun=0, IE=0, holding=8'h00, FSM=IDLE, txd=1, intr=0. Reset mid-frame aborts the frame; txd=1 after that edge.
- Read TDATA (we=0, abus==TDATA_ADDR):
  - returns {24'b0, holding byte} combinationally;
  - no side effects.
- Read TCTRL: returns {23'b0, IE, 5'b0, Overrun, Busy, Ready} combinationally.
- Write TDATA with registered Ready=1: holding <= dbus[7:0]; Ready <= 0.
- Write TDATA with registered Ready=0: data discarded; Overrun <= 1.
- Write TCTRL:
  - IE <= dbus[8];
  - dbus[2]=0 clears Overrun; dbus[2]=1 leaves it unchanged;
  - Ready and Busy ignore writes.
- Overrun set and clear in the same cycle: set wins. This cannot occur on one bus cycle; the rule is stated for completeness.
- Accesses to any other address: no effect, dbus not driven.
- Transmit FSM states: IDLE, START, DATA, STOP. A baud counter runs 0..BAUD_DIV-1 in every non-IDLE state. A bit index runs 0..7 in DATA.
  - IDLE & Ready=0: shifter <= holding; Ready <= 1; txd <= 0; go to START; counter cleared. Latency is 1 clk from the write edge to the start bit.
  - START: after BAUD_DIV clks, go to DATA; txd <= shifter[0].
  - DATA: every BAUD_DIV clks, shift right and drive the next bit. After bit 7 has been held BAUD_DIV clks, go to STOP; txd <= 1.
  - STOP: txd=1 for BAUD_DIV clks. At the end:
    - if Ready=0 (new byte pending), load the shifter, set Ready <= 1, go directly to START (no idle gap);
    - otherwise go to IDLE.
- Frame length is exactly 10*BAUD_DIV clks. The txd transition is registered, aligned to the counter wrap.
- Ready and the FSM load in the same edge as a TDATA write: the write is judged on the pre-edge Ready. If Ready=0 then, the byte is dropped and Overrun is set, even though the FSM empties the buffer on that edge.
- Busy=1 from the edge entering START until the edge returning to IDLE.
- intr is combinational from registered Ready and IE; it is not sticky.

Test Plan:
All scenarios use BAUD_DIV=4.
1. Reset held 2 clks, then released:
   - txd=1, intr=0;
   - read TCTRL → 32'h00000001;
   - read TDATA → 0;
   - read address F0000034 → dbus=z.
2. Write TDATA=32'h000001A5:
   - Ready=0 for 1 clk, then 1;
   - txd holds 0 for 4 clks, then 1,0,1,0,0,1,0,1 for 4 clks each, then stop bit 1 for 4 clks (40 clks total);
   - TCTRL reads 32'h3 mid-frame and 32'h1 after the stop bit.
3. Write 0x55, then 0x0F once Ready=1, then 0x77 while Ready=0:
   - two contiguous frames, 80 clks with no idle gap between stop and start;
   - 0x77 never transmitted;
   - TCTRL bit2=1.
4. Overrun clearing:
   - with Overrun=1, write TCTRL=32'h104 → Overrun stays 1;
   - write TCTRL=32'h100 → Overrun=0, IE=1.
5. Interrupt behaviour:
   - IE=1 and idle → intr=1;
   - write TDATA → intr=0 for exactly 1 clk;
   - write TCTRL=0 → intr=0.
6. Reset mid-frame, during data bit 3 of 0xC3:
   - txd=1 after the reset edge, TCTRL=1, FSM idle;
   - a following write of 0x81 produces a clean 40-clk frame.
